fnd_select_decoder: RTL and testbench
=====================================

// Module: fnd_select_decoder
// PURPOSE
//  - Digit-select (anode/common) decoder for a 4-digit FND (7-segment) display.
//  - Converts 2-bit digit index + enable into a one-hot/one-cold 4-bit digit strobe.
//  - Sits between the display scan counter and the FND common pins; segment data path is separate.
//  - Output is registered: glitch-free strobes, fixed 1-cycle latency.
// PARAMETERS
//  - ACTIVE_LOW  default 1  1: selected digit driven 0, others 1 (common-anode); 0: selected digit 1, others 0
// PORTS
//  - i_clk          in   1  system clock, all state on rising edge
//  - i_reset        in   1  reset; one clock; reset is synchronous and active-high
//  - i_DigitSelect  in   2  digit index 0..3 (0 = digit 0 / o_digit[0])
//  - i_En           in   1  1: drive selected digit; 0: all digits off
//  - o_digit        out  4  registered digit strobe, polarity per ACTIVE_LOW
// BEHAVIOUR
//  - "Off" pattern OFF = 4'b1111 if ACTIVE_LOW=1, 4'b0000 if ACTIVE_LOW=0.
//  - Reset: on rising i_clk with i_reset=1, o_digit <= OFF. Reset has priority over i_En/i_DigitSelect.
//  - Normal, i_reset=0, each rising i_clk:
//      i_En=0 -> o_digit <= OFF (regardless of i_DigitSelect)
//      i_En=1 -> o_digit <= exactly one active bit at index i_DigitSelect
//  - ACTIVE_LOW=1 map (i_En=1): 00->4'b1110, 01->4'b1101, 10->4'b1011, 11->4'b0111.
//  - ACTIVE_LOW=0 map (i_En=1): 00->4'b0001, 01->4'b0010, 10->4'b0100, 11->4'b1000.
//  - Latency: exactly 1 cycle from input sample to o_digit; no combinational path input->output.
//  - Never more than one digit active in any cycle; output only changes on clock edges.
//  - Inputs held constant -> o_digit stable; no internal state other than the output register.
//  - Reset asserted mid-scan: next edge forces OFF; first edge after release loads current inputs.
//  - X/Z on inputs not handled specially (synthesis-style decode, no default beyond OFF when disabled).
// TESTING
//  - Reset: i_reset=1 one edge, any inputs -> o_digit=4'b1111 (ACTIVE_LOW=1).
//  - Enabled sweep: i_En=1, i_DigitSelect 00,01,10,11 on successive edges -> 1110,1101,1011,0111, each one cycle after input.
//  - Disabled sweep: i_En=0, i_DigitSelect 00..11 -> 4'b1111 every cycle.
//  - Enable toggle: sel=10, i_En 1->0->1 -> 1011,1111,1011 with 1-cycle lag.
//  - Reset priority: i_reset=1 with i_En=1, sel=01 -> 1111; release -> 1101 next edge.
//  - ACTIVE_LOW=0 build: i_En=1 sweep -> 0001,0010,0100,1000; i_En=0 or reset -> 0000.

Source files
------------

// File: rtl/fnd_select_decoder.sv
// Digit-select (common pin) decoder for a 4-digit 7-segment display.
// Turns a 2-bit digit index plus an enable into a registered 4-bit strobe
// with exactly one active digit, or none when the enable is low.
module fnd_select_decoder #(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [1:0] i_DigitSelect,
  input  logic       i_En,
  output logic [3:0] o_digit
);

  localparam logic [3:0] OFF = ACTIVE_LOW ? 4'b1111 : 4'b0000;

  // One-hot strobe for the selected digit, before polarity is applied.
  function automatic logic [3:0] decode_onehot(input logic [1:0] sel);
    logic [3:0] onehot;
    onehot = 4'b0000;
    unique case (sel)
      2'd0: onehot = 4'b0001;
      2'd1: onehot = 4'b0010;
      2'd2: onehot = 4'b0100;
      2'd3: onehot = 4'b1000;
      default: onehot = 4'b0000;
    endcase
    return onehot;
  endfunction

  // Common-anode parts want the selected pin pulled low, so invert.
  function automatic logic [3:0] apply_polarity(input logic [3:0] onehot);
    return ACTIVE_LOW ? ~onehot : onehot;
  endfunction

  logic [3:0] digit_d;
  logic [3:0] digit_q;

  // Next strobe: reset and disable both blank the display, reset first.
  always_comb begin
    digit_d = OFF;
    if (i_reset) begin
      digit_d = OFF;
    end else if (i_En) begin
      digit_d = apply_polarity(decode_onehot(i_DigitSelect));
    end
  end

  // Output register keeps strobes glitch-free with a fixed one-cycle lag.
  always_ff @(posedge i_clk) begin
    digit_q <= digit_d;
  end

  assign o_digit = digit_q;

endmodule

// File: tb/tb_fnd_select_decoder.sv
// Scoreboard bench for fnd_select_decoder: one common-anode and one
// common-cathode instance share the same stimulus.
module tb_fnd_select_decoder;

  logic       clk;
  logic       rst;
  logic [1:0] sel;
  logic       en;
  logic [3:0] digit_al;
  logic [3:0] digit_ah;

  int n_checks;
  int n_fail;

  logic [3:0] exp_al_q[$];
  logic [3:0] exp_ah_q[$];
  string      tag_q[$];

  logic [3:0] prev_al;
  logic [3:0] prev_ah;
  bit         have_prev;

  fnd_select_decoder #(.ACTIVE_LOW(1'b1)) dut_al (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_DigitSelect(sel),
    .i_En         (en),
    .o_digit      (digit_al)
  );

  fnd_select_decoder #(.ACTIVE_LOW(1'b0)) dut_ah (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_DigitSelect(sel),
    .i_En         (en),
    .o_digit      (digit_ah)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: the output is presented every cycle, so pop one entry per edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_al_q.size() > 0) begin
        logic [3:0] e_al;
        logic [3:0] e_ah;
        string      t;
        e_al = exp_al_q.pop_front();
        e_ah = exp_ah_q.pop_front();
        t    = tag_q.pop_front();
        n_checks++;
        if (digit_al !== e_al) begin
          n_fail++;
          $display("FAIL %s (active-low): got %b, expected %b", t, digit_al, e_al);
        end
        n_checks++;
        if (digit_ah !== e_ah) begin
          n_fail++;
          $display("FAIL %s (active-high): got %b, expected %b", t, digit_ah, e_ah);
        end
      end
    end
  end

  // Drive one edge worth of inputs; expected values are the hand-derived
  // output after the next rising edge. Also confirm that changing inputs
  // does not move the output before that edge.
  task automatic step(input logic r, input logic e, input logic [1:0] s,
                      input logic [3:0] x_al, input logic [3:0] x_ah,
                      input string t);
    @(negedge clk);
    rst = r;
    en  = e;
    sel = s;
    exp_al_q.push_back(x_al);
    exp_ah_q.push_back(x_ah);
    tag_q.push_back(t);
    #1;
    if (have_prev) begin
      n_checks++;
      if (digit_al !== prev_al || digit_ah !== prev_ah) begin
        n_fail++;
        $display("FAIL %s no_comb_path: got %b/%b, expected %b/%b",
                 t, digit_al, digit_ah, prev_al, prev_ah);
      end
    end
    prev_al   = x_al;
    prev_ah   = x_ah;
    have_prev = 1'b1;
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    have_prev = 1'b0;
    rst = 1'b0;
    en  = 1'b0;
    sel = 2'd0;

    step(1'b1, 1'b1, 2'd1, 4'b1111, 4'b0000, "reset");

    step(1'b0, 1'b1, 2'd0, 4'b1110, 4'b0001, "en_sel0");
    step(1'b0, 1'b1, 2'd1, 4'b1101, 4'b0010, "en_sel1");
    step(1'b0, 1'b1, 2'd2, 4'b1011, 4'b0100, "en_sel2");
    step(1'b0, 1'b1, 2'd3, 4'b0111, 4'b1000, "en_sel3");

    step(1'b0, 1'b0, 2'd0, 4'b1111, 4'b0000, "dis_sel0");
    step(1'b0, 1'b0, 2'd1, 4'b1111, 4'b0000, "dis_sel1");
    step(1'b0, 1'b0, 2'd2, 4'b1111, 4'b0000, "dis_sel2");
    step(1'b0, 1'b0, 2'd3, 4'b1111, 4'b0000, "dis_sel3");

    step(1'b0, 1'b1, 2'd2, 4'b1011, 4'b0100, "toggle_on1");
    step(1'b0, 1'b0, 2'd2, 4'b1111, 4'b0000, "toggle_off");
    step(1'b0, 1'b1, 2'd2, 4'b1011, 4'b0100, "toggle_on2");

    step(1'b1, 1'b1, 2'd1, 4'b1111, 4'b0000, "rst_priority");
    step(1'b0, 1'b1, 2'd1, 4'b1101, 4'b0010, "rst_release");

    step(1'b0, 1'b1, 2'd3, 4'b0111, 4'b1000, "scan_sel3");
    step(1'b1, 1'b1, 2'd3, 4'b1111, 4'b0000, "rst_midscan");
    step(1'b0, 1'b1, 2'd3, 4'b0111, 4'b1000, "post_rst_load");
    step(1'b0, 1'b1, 2'd3, 4'b0111, 4'b1000, "hold1");
    step(1'b0, 1'b1, 2'd3, 4'b0111, 4'b1000, "hold2");
    step(1'b0, 1'b1, 2'd0, 4'b1110, 4'b0001, "wrap_sel0");

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && exp_al_q.size() > 0; i++) begin
      @(posedge clk);
      #2;
    end
    n_checks++;
    if (exp_al_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending entries, expected 0", exp_al_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
